mont_mul_ws: RTL
================

# mont_mul_ws

Parametrised word-serial Montgomery modular multiplier (CIOS) computing u·v·2^-WIDTH mod N with a single WORD×WORD multiply-accumulate per cycle. It is the next-generation datapath for the modular-exponentiation engine.

Compared with the fixed-size unprotected multiplier, it adds:
- run-time loadable modulus N and N';
- valid/ready operand and result streams;
- word-serial final subtraction;
- status and error reporting.

## Interface
Parameters:
- WIDTH, 2048, operand/modulus width in bits; WIDTH % WORD == 0
- WORD, 64, word and bus width in bits; ≥ 8
- S (localparam), WIDTH/WORD, words per operand

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- load_mod  in  1  qualifies start: 1 = stream N and N' before the operands
- in_data  in  WORD  operand word, least-significant word first
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  WORD  result word, least-significant first
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- out_last  out  1  marks result word S-1
- busy  out  1  high from accepted start until the last result word is accepted
- done  out  1  one-cycle pulse on acceptance of the last result word
- mod_valid  out  1  a modulus is stored
- err  out  1  one-cycle pulse: start with load_mod=0 while mod_valid=0

## Operation
- **Reset values:** all outputs 0; all state cleared, including mod_valid and the stored N and N'.
- **States:** IDLE, LD_N, LD_NP, LD_U, LD_V, MUL_UV, CARRY_UV, M_CALC, MUL_MN, SHIFT, SUB, OUT.
- **IDLE:**
  - start & load_mod → LD_N.
  - start & !load_mod & mod_valid → LD_U.
  - start & !load_mod & !mod_valid → err pulse, stay in IDLE.
  - start while busy is ignored.
- **Load states:**
  - in_ready=1; a word is stored on in_valid&in_ready.
  - LD_N takes S words, LD_NP takes 1 word, LD_U takes S words, LD_V takes S words.
  - mod_valid is set on the last LD_NP word.
  - in_valid low stalls the load indefinitely.
- **Outer loop i = 0..S-1.** t has S+2 words, zeroed at LD_U entry.
  - MUL_UV, j = 0..S-1: (C, t[j]) = t[j] + u[i]·v[j] + C.
  - CARRY_UV: (t[S+1], t[S]) = t[S] + C.
  - M_CALC: m = t[0]·N' mod 2^WORD.
  - MUL_MN, j = 0..S-1: (C, t[j]) = t[j] + m·N[j] + C. The j=0 result word is discarded.
  - SHIFT: t[S] + C is folded in, t is shifted down one word, i advances.
- **Arithmetic widths:** MAC result is 2·WORD bits; carry C is WORD bits, reset to 0 at the start of each MUL phase.
- **SUB:** S+1 cycles, d = t − N word-serially with borrow. Result = d when the final borrow is 0 (including t == N, giving 0), else t.
- **OUT:**
  - Streams S words.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - Returns to IDLE on acceptance of the final word.
- **Operand preconditions:** N odd, N' = −N^-1 mod 2^WORD, u, v < N. These are not checked; the result is undefined if they are violated.

## Timing
- Compute latency from acceptance of the last v word to the first out_valid: S·(2S+3) + (S+1) + 1 cycles. For the default parameters this is 2178 cycles.
- in_ready is 0 outside load states. No combinational path from in_valid to in_ready or from out_ready to out_valid.
- **OUT throughput:** one word per cycle when out_ready is held high.
- **done:** pulses in the same cycle the last word is accepted; busy falls the next cycle.
- **Reset mid-operation:** immediate return to IDLE; partial results are lost and mod_valid is cleared.

## Structure
- **Package mont_pkg:**
  - state enum;
  - function computing S from WIDTH and WORD;
  - word add-with-carry function.
- **Sub-module mont_word_mac:** combinational a·b + c + d with WORD-bit inputs and a 2·WORD-bit output.
- All other logic (FSM, counters i/j, word arrays for N, u, v, t, d) lives in the top level.

## Test plan
Bench parameters: WIDTH=64, WORD=16. Modulus N=0xFFFF_FFFF_FFFF_FFFF, N'=0x0001; with this N, R mod N = 1.
- Load N/N' with u=1, v=0x0123_4567_89AB_CDEF → result 0x0123_4567_89AB_CDEF. Words out 0xCDEF, 0x89AB, 0x4567, 0x0123; out_last on the 4th; done pulses once.
- Reuse the stored modulus (load_mod=0) with u=2, v=3 → result 0x0000_0000_0000_0006. First out_valid exactly 4·11+5+1 = 50 cycles after the last v word.
- u = v = 0xFFFF_FFFF_FFFF_FFFE → result 0x0000_0000_0000_0001 (exercises the final subtraction path).
- After reset, start with load_mod=0 → err pulses once, busy stays 0, in_ready stays 0.
- During OUT, hold out_ready low for 5 cycles → out_data and out_last stable, no word lost or duplicated.
- Assert reset mid-MUL_MN → all outputs 0 and mod_valid=0 next cycle. A subsequent start with load_mod=0 → err.

Source files
------------

// File: rtl/mont_pkg.sv
// ---------------------------------------------------------------------------
// mont_pkg
// Shared types and helpers for the word-serial Montgomery multiplier.
//   state_e      : FSM state encoding (ST_IDLE encodes as 0)
//   mont_words   : number of WORD-bit words in a WIDTH-bit operand
//   mont_add_wc  : add-with-carry on zero-extended words; the caller keeps
//                  bits [WORD:0] of the result ({carry, sum})
// ---------------------------------------------------------------------------
package mont_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LD_N     = 4'd1,
    ST_LD_NP    = 4'd2,
    ST_LD_U     = 4'd3,
    ST_LD_V     = 4'd4,
    ST_MUL_UV   = 4'd5,
    ST_CARRY_UV = 4'd6,
    ST_M_CALC   = 4'd7,
    ST_MUL_MN   = 4'd8,
    ST_SHIFT    = 4'd9,
    ST_SUB      = 4'd10,
    ST_OUT      = 4'd11
  } state_e;

  // Widest word the add helper supports; words narrower than this are
  // zero-extended by the caller, so the carry lands at bit WORD.
  localparam int unsigned MONT_MAX_WORD = 128;

  function automatic int unsigned mont_words(input int unsigned width,
                                             input int unsigned word);
    return width / word;
  endfunction

  function automatic logic [MONT_MAX_WORD:0] mont_add_wc(
    input logic [MONT_MAX_WORD-1:0] a,
    input logic [MONT_MAX_WORD-1:0] b,
    input logic                     cin
  );
    return {1'b0, a} + {1'b0, b} + {{MONT_MAX_WORD{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/mont_mul_ws_if.sv
// ---------------------------------------------------------------------------
// mont_mul_ws_if
// Operand and result streams of the Montgomery multiplier.
//   in_data/in_valid/in_ready      : operand words, least-significant first
//   out_data/out_valid/out_ready   : result words, least-significant first
//   out_last                       : marks the final result word
//
// Handshake: a word transfers on a rising clk edge where valid && ready.
// Once valid is raised the source holds data (and last) stable until the
// transfer; ready may rise or fall freely and never depends combinationally
// on valid of the same stream.
//
// Modports: slave = the multiplier, master = the operand source/result sink.
// ---------------------------------------------------------------------------
interface mont_mul_ws_if #(
  parameter int WORD = 64
);
  logic [WORD-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [WORD-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/mont_word_mac.sv
// ---------------------------------------------------------------------------
// mont_word_mac
// Combinational word multiply-accumulate: o_p = i_a * i_b + i_c + i_d.
// The worst case (2^W-1)^2 + 2(2^W-1) = 2^2W - 1 always fits in 2*WORD bits.
//   i_a, i_b : multiplicands (WORD bits)
//   i_c, i_d : addends (WORD bits)
//   o_p      : 2*WORD-bit result
// ---------------------------------------------------------------------------
module mont_word_mac #(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0]   i_a,
  input  logic [WORD-1:0]   i_b,
  input  logic [WORD-1:0]   i_c,
  input  logic [WORD-1:0]   i_d,
  output logic [2*WORD-1:0] o_p
);
  logic [2*WORD-1:0] w_a;
  logic [2*WORD-1:0] w_b;
  logic [2*WORD-1:0] w_c;
  logic [2*WORD-1:0] w_d;

  assign w_a = {{WORD{1'b0}}, i_a};
  assign w_b = {{WORD{1'b0}}, i_b};
  assign w_c = {{WORD{1'b0}}, i_c};
  assign w_d = {{WORD{1'b0}}, i_d};
  assign o_p = (w_a * w_b) + w_c + w_d;
endmodule

// File: rtl/mont_mul_ws.sv
// ---------------------------------------------------------------------------
// mont_mul_ws
// Word-serial CIOS Montgomery multiplier: result = u * v * 2^-WIDTH mod N,
// one WORD x WORD multiply-accumulate per cycle, word-serial final
// subtraction, run-time loadable N and N' (= -N^-1 mod 2^WORD).
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a job (sampled only in IDLE)
//   load_mod    : with start, stream N (S words) and N' (1 word) first
//   bus         : operand/result streams (mont_mul_ws_if.slave)
//   busy        : job in progress
//   done        : pulse on acceptance of the last result word
//   mod_valid   : a modulus is stored
//   err         : pulse when a job is started with no stored modulus
//   dbg_state   : current FSM state
// ---------------------------------------------------------------------------
module mont_mul_ws
  import mont_pkg::*;
#(
  parameter int WIDTH = 2048,
  parameter int WORD  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_mod,
  mont_mul_ws_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          mod_valid,
  output logic          err,
  output state_e        dbg_state
);
  localparam int S  = int'(mont_words(WIDTH, WORD));
  localparam int SW = (S > 1) ? $clog2(S) : 1;   // index into S-word arrays
  localparam int TW = $clog2(S + 2);             // index into t, also counts to S
  localparam int MW = int'(MONT_MAX_WORD);

  localparam logic [TW-1:0] IDX_SM1 = TW'(S - 1);
  localparam logic [TW-1:0] IDX_S   = TW'(S);
  localparam logic [TW-1:0] IDX_S1  = TW'(S + 1);
  localparam logic [SW-1:0] I_LAST  = SW'(S - 1);

  // ---------------- state and storage ----------------
  state_e          r_state;
  state_e          w_next;

  logic [WORD-1:0] r_n [S];
  logic [WORD-1:0] r_u [S];
  logic [WORD-1:0] r_v [S];
  logic [WORD-1:0] r_d [S];
  logic [WORD-1:0] r_t [S+2];
  logic [WORD-1:0] r_np;
  logic [WORD-1:0] r_m;
  logic [WORD-1:0] r_c;
  logic [TW-1:0]   r_j;
  logic [SW-1:0]   r_i;
  logic            r_borrow;
  logic            r_sel_d;
  logic            r_mod_valid;
  logic            r_err;

  // ---------------- shared helpers ----------------
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_j_last;
  logic            w_j_sub_last;
  logic            w_i_last;
  logic [SW-1:0]   w_js;
  logic            w_load_st;

  assign w_js         = r_j[SW-1:0];
  assign w_j_last     = (r_j == IDX_SM1);
  assign w_j_sub_last = (r_j == IDX_S);
  assign w_i_last     = (r_i == I_LAST);
  assign w_load_st    = (r_state == ST_LD_N)  || (r_state == ST_LD_NP) ||
                        (r_state == ST_LD_U)  || (r_state == ST_LD_V);
  assign w_in_fire    = bus.in_valid  && w_load_st;
  assign w_out_fire   = bus.out_ready && (r_state == ST_OUT);

  // ---------------- outputs ----------------
  assign bus.in_ready  = w_load_st;
  assign bus.out_valid = (r_state == ST_OUT);
  assign bus.out_last  = (r_state == ST_OUT) && w_j_last;
  assign bus.out_data  = (r_state != ST_OUT) ? '0 :
                         (r_sel_d ? r_d[w_js] : r_t[r_j]);
  assign busy          = (r_state != ST_IDLE);
  assign done          = w_out_fire && w_j_last;
  assign mod_valid     = r_mod_valid;
  assign err           = r_err;
  assign dbg_state     = r_state;

  // ---------------- multiply-accumulate ----------------
  logic [WORD-1:0]   w_mac_a;
  logic [WORD-1:0]   w_mac_b;
  logic [WORD-1:0]   w_mac_c;
  logic [WORD-1:0]   w_mac_d;
  logic [2*WORD-1:0] w_mac;

  // The one multiplier serves u*v, m*N and also m = t[0]*N' (low word only).
  always_comb begin
    w_mac_a = '0;
    w_mac_b = '0;
    w_mac_c = '0;
    w_mac_d = '0;
    case (r_state)
      ST_MUL_UV: begin
        w_mac_a = r_u[r_i];
        w_mac_b = r_v[w_js];
        w_mac_c = r_t[r_j];
        w_mac_d = r_c;
      end
      ST_M_CALC: begin
        w_mac_a = r_t[0];
        w_mac_b = r_np;
      end
      ST_MUL_MN: begin
        w_mac_a = r_m;
        w_mac_b = r_n[w_js];
        w_mac_c = r_t[r_j];
        w_mac_d = r_c;
      end
      default: ;
    endcase
  end

  mont_word_mac #(.WORD(WORD)) u_mac (
    .i_a (w_mac_a),
    .i_b (w_mac_b),
    .i_c (w_mac_c),
    .i_d (w_mac_d),
    .o_p (w_mac)
  );

  // ---------------- word adder (carry fold and subtraction) ----------------
  logic [WORD-1:0] w_add_a;
  logic [WORD-1:0] w_add_b;
  logic            w_add_cin;
  logic [WORD:0]   w_add;

  // Subtraction is t + ~N + !borrow; the word above N's top word is zero,
  // so its complement is all ones.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      ST_CARRY_UV, ST_SHIFT: begin
        w_add_a = r_t[IDX_S];
        w_add_b = r_c;
      end
      ST_SUB: begin
        w_add_a   = r_t[r_j];
        w_add_b   = w_j_sub_last ? '1 : ~r_n[w_js];
        w_add_cin = ~r_borrow;
      end
      default: ;
    endcase
  end

  assign w_add = (WORD+1)'(mont_add_wc(MW'(w_add_a), MW'(w_add_b), w_add_cin));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (load_mod)         w_next = ST_LD_N;
          else if (r_mod_valid) w_next = ST_LD_U;
        end
      end
      ST_LD_N:     if (w_in_fire && w_j_last) w_next = ST_LD_NP;
      ST_LD_NP:    if (w_in_fire)             w_next = ST_LD_U;
      ST_LD_U:     if (w_in_fire && w_j_last) w_next = ST_LD_V;
      ST_LD_V:     if (w_in_fire && w_j_last) w_next = ST_MUL_UV;
      ST_MUL_UV:   if (w_j_last)              w_next = ST_CARRY_UV;
      ST_CARRY_UV:                            w_next = ST_M_CALC;
      ST_M_CALC:                              w_next = ST_MUL_MN;
      ST_MUL_MN:   if (w_j_last)              w_next = ST_SHIFT;
      ST_SHIFT:    w_next = w_i_last ? ST_SUB : ST_MUL_UV;
      ST_SUB:      if (w_j_sub_last)          w_next = ST_OUT;
      ST_OUT:      if (w_out_fire && w_j_last) w_next = ST_IDLE;
      default:                                w_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < S; k++) begin
        r_n[k] <= '0;
        r_u[k] <= '0;
        r_v[k] <= '0;
        r_d[k] <= '0;
      end
      for (int k = 0; k < S + 2; k++) r_t[k] <= '0;
      r_np        <= '0;
      r_m         <= '0;
      r_c         <= '0;
      r_j         <= '0;
      r_i         <= '0;
      r_borrow    <= 1'b0;
      r_sel_d     <= 1'b0;
      r_mod_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (r_state == ST_IDLE) && start && !load_mod && !r_mod_valid;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_j <= '0;
            if (!load_mod) for (int k = 0; k < S + 2; k++) r_t[k] <= '0;
          end
        end
        ST_LD_N: begin
          if (w_in_fire) begin
            r_n[w_js] <= bus.in_data;
            r_j       <= w_j_last ? '0 : r_j + TW'(1);
          end
        end
        ST_LD_NP: begin
          if (w_in_fire) begin
            r_np        <= bus.in_data;
            r_mod_valid <= 1'b1;
            r_j         <= '0;
            for (int k = 0; k < S + 2; k++) r_t[k] <= '0;
          end
        end
        ST_LD_U: begin
          if (w_in_fire) begin
            r_u[w_js] <= bus.in_data;
            r_j       <= w_j_last ? '0 : r_j + TW'(1);
          end
        end
        ST_LD_V: begin
          if (w_in_fire) begin
            r_v[w_js] <= bus.in_data;
            r_j       <= w_j_last ? '0 : r_j + TW'(1);
            r_i       <= '0;
            r_c       <= '0;
          end
        end
        ST_MUL_UV, ST_MUL_MN: begin
          // In MUL_MN the j=0 word is zero by choice of m; the shift drops it.
          r_t[r_j] <= w_mac[WORD-1:0];
          r_c      <= w_mac[2*WORD-1:WORD];
          r_j      <= w_j_last ? '0 : r_j + TW'(1);
        end
        ST_CARRY_UV: begin
          r_t[IDX_S]  <= w_add[WORD-1:0];
          r_t[IDX_S1] <= {{(WORD-1){1'b0}}, w_add[WORD]};
        end
        ST_M_CALC: begin
          r_m <= w_mac[WORD-1:0];
          r_c <= '0;
        end
        ST_SHIFT: begin
          for (int k = 0; k < S - 1; k++) r_t[k] <= r_t[k+1];
          r_t[IDX_SM1] <= w_add[WORD-1:0];
          r_t[IDX_S]   <= r_t[IDX_S1] + {{(WORD-1){1'b0}}, w_add[WORD]};
          r_t[IDX_S1]  <= '0;
          r_c          <= '0;
          r_j          <= '0;
          r_borrow     <= 1'b0;
          r_i          <= w_i_last ? '0 : r_i + SW'(1);
        end
        ST_SUB: begin
          // Carry out of t + ~N + !borrow is the inverse of the borrow.
          if (!w_j_sub_last) r_d[w_js] <= w_add[WORD-1:0];
          r_borrow <= ~w_add[WORD];
          if (w_j_sub_last) begin
            r_sel_d <= w_add[WORD];
            r_j     <= '0;
          end else begin
            r_j     <= r_j + TW'(1);
          end
        end
        ST_OUT: begin
          if (w_out_fire) r_j <= w_j_last ? '0 : r_j + TW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
